// File: rtl/fifo_wptr_full.sv
// Write-side pointer / flag generator for the async FIFO (write clock domain).
// Produces the storage write address, Gray write pointer for the read-side
// synchronizer, full / almost-full flags, occupancy and sticky overflow.
module fifo_wptr_full #(
  parameter int addr_width = 4,
  parameter int af_level   = 2
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_inc,
  input  logic [addr_width:0]   wq2_rd_ptr,
  input  logic                  ovf_clr,
  output logic [addr_width-1:0] w_address,
  output logic [addr_width:0]   w_ptr,
  output logic                  full_flag,
  output logic                  almost_full,
  output logic [addr_width:0]   w_count,
  output logic                  w_overflow
);

  localparam int depth = 1 << addr_width;
  localparam logic [addr_width:0] af_thresh = (addr_width+1)'(depth - af_level);

  logic [addr_width:0] wbin;
  logic [addr_width:0] wbin_n;
  logic [addr_width:0] wgray_n;
  logic [addr_width:0] rbin;
  logic [addr_width:0] count_n;
  logic [addr_width:0] full_cmp;
  logic                push;
  logic                full_n;
  logic                af_n;

  // Gray -> binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= addr_width; i++)
      rbin[i] = ^(wq2_rd_ptr >> i);
  end

  // Next pointer, occupancy and flag values; push is qualified by the
  // registered full flag exactly as the memory write enable is.
  always_comb begin
    push     = w_inc & ~full_flag;
    wbin_n   = wbin + {{addr_width{1'b0}}, push};
    wgray_n  = (wbin_n >> 1) ^ wbin_n;
    count_n  = wbin_n - rbin;
    // Full when the write pointer is one lap ahead: top two Gray bits
    // inverted, remaining bits equal.
    full_cmp = {~wq2_rd_ptr[addr_width:addr_width-1], wq2_rd_ptr[addr_width-2:0]};
    full_n   = (wgray_n == full_cmp);
    af_n     = (count_n >= af_thresh);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin        <= '0;
      w_ptr       <= '0;
      full_flag   <= 1'b0;
      w_count     <= '0;
      almost_full <= 1'b0;
    end else begin
      wbin        <= wbin_n;
      w_ptr       <= wgray_n;
      full_flag   <= full_n;
      w_count     <= count_n;
      almost_full <= af_n;
    end
  end

  // Sticky overflow: a rejected write sets it; set beats a same-cycle clear.
  always_ff @(posedge w_clk) begin
    if (w_rst)                  w_overflow <= 1'b0;
    else if (w_inc & full_flag) w_overflow <= 1'b1;
    else if (ovf_clr)           w_overflow <= 1'b0;
  end

  // Address is a direct slice of the binary pointer register.
  assign w_address = wbin[addr_width-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (addr_width=4, af_level=2).
module tb_fifo_wptr_full;

  logic       w_clk = 1'b0;
  logic       w_rst;
  logic       w_inc;
  logic [4:0] wq2_rd_ptr;
  logic       ovf_clr;
  logic [3:0] w_address;
  logic [4:0] w_ptr;
  logic       full_flag;
  logic       almost_full;
  logic [4:0] w_count;
  logic       w_overflow;

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(.addr_width(4), .af_level(2)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_inc(w_inc), .wq2_rd_ptr(wq2_rd_ptr),
    .ovf_clr(ovf_clr), .w_address(w_address), .w_ptr(w_ptr),
    .full_flag(full_flag), .almost_full(almost_full), .w_count(w_count),
    .w_overflow(w_overflow)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " addr"},  32'(w_address),   0);
    chk({tag, " ptr"},   32'(w_ptr),       0);
    chk({tag, " count"}, 32'(w_count),     0);
    chk({tag, " full"},  32'(full_flag),   0);
    chk({tag, " af"},    32'(almost_full), 0);
    chk({tag, " ovf"},   32'(w_overflow),  0);
  endtask

  initial begin
    logic [4:0] b;
    logic [4:0] r;

    // Reset
    w_rst = 1'b1; w_inc = 1'b1; wq2_rd_ptr = '0; ovf_clr = 1'b0;
    step(); step();
    chk_all_zero("reset");

    // 1. Fill to full with the read pointer parked at 0
    w_rst = 1'b0; w_inc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      b = 5'(i);
      chk("fill addr",  32'(w_address),   32'(i % 16));
      chk("fill ptr",   32'(w_ptr),       32'(gray(b)));
      chk("fill count", 32'(w_count),     32'(i));
      chk("fill af",    32'(almost_full), 32'(i >= 14));
      chk("fill full",  32'(full_flag),   32'(i == 16));
      chk("fill ovf",   32'(w_overflow),  0);
    end
    step(); // 17th request is rejected
    chk("ovf17 addr",  32'(w_address),  0);
    chk("ovf17 ovf",   32'(w_overflow), 1);
    chk("ovf17 count", 32'(w_count),    16);
    chk("ovf17 full",  32'(full_flag),  1);
    chk("ovf17 ptr",   32'(w_ptr),      32'(5'b11000));

    // 2. Overflow clear, then set-wins-over-clear
    w_inc = 1'b0; ovf_clr = 1'b1;
    step();
    chk("clr ovf",  32'(w_overflow), 0);
    chk("clr full", 32'(full_flag),  1);
    w_inc = 1'b1; ovf_clr = 1'b1;
    step();
    chk("setwin ovf",  32'(w_overflow), 1);
    chk("setwin addr", 32'(w_address),  0);
    w_inc = 1'b0; ovf_clr = 1'b0;

    // 3. Full release when the reader frees one slot
    wq2_rd_ptr = 5'b00001;
    step();
    chk("rel full",  32'(full_flag),   0);
    chk("rel count", 32'(w_count),     15);
    chk("rel af",    32'(almost_full), 1);
    w_inc = 1'b1;
    step();
    chk("refill full",  32'(full_flag), 1);
    chk("refill addr",  32'(w_address), 1);
    chk("refill count", 32'(w_count),   16);
    w_inc = 1'b0;

    // 4. Simultaneous push and read advance
    wq2_rd_ptr = 5'b00011; // Gray of 2
    step();
    chk("sim0 count", 32'(w_count),   15);
    chk("sim0 full",  32'(full_flag), 0);
    w_inc = 1'b1; wq2_rd_ptr = 5'b00010; // Gray of 3
    step();
    chk("sim count", 32'(w_count),   15);
    chk("sim full",  32'(full_flag), 0);
    chk("sim addr",  32'(w_address), 2);
    w_inc = 1'b0;

    // 5. Wrap-around with the reader trailing two writes behind
    w_rst = 1'b1; wq2_rd_ptr = '0;
    step();
    chk_all_zero("rst2");
    w_rst = 1'b0; w_inc = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = (k == 0) ? 5'd0 : 5'(k - 1);
      wq2_rd_ptr = gray(r);
      step();
      b = 5'(k + 1);
      chk("wrap addr",  32'(w_address),   32'(b[3:0]));
      chk("wrap ptr",   32'(w_ptr),       32'(gray(b)));
      chk("wrap count", 32'(w_count),     (k == 0) ? 1 : 2);
      chk("wrap full",  32'(full_flag),   0);
      chk("wrap af",    32'(almost_full), 0);
      if (k == 30) chk("wrap ptr31", 32'(w_ptr), 32'(5'b10000));
      if (k == 31) begin
        chk("wrap ptr0",  32'(w_ptr),     0);
        chk("wrap addr0", 32'(w_address), 0);
      end
    end

    // 6. Mid-operation reset discards state and the concurrent write
    w_rst = 1'b1; w_inc = 1'b0; wq2_rd_ptr = '0;
    step();
    w_rst = 1'b0; w_inc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid5 count", 32'(w_count),   5);
    chk("mid5 addr",  32'(w_address), 5);
    w_rst = 1'b1; w_inc = 1'b1;
    step();
    chk_all_zero("midrst");
    w_rst = 1'b0; w_inc = 1'b0;
    step();
    chk_all_zero("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
